// File: rtl/sr_data_mem.sv
// Data memory plus MMIO block behind the core's load/store port.
// Byte-addressed RAM with sized stores and a lane-shifted combinational read.
// The MMIO window holds a console TX FIFO, a status register and a cycle counter.
module sr_data_mem #(
  parameter int unsigned WORDS      = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  write_byte_en,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        store_fault
);

  localparam int unsigned AW = $clog2(WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(WORDS * 4);

  logic [31:0]   mem     [WORDS];
  logic [7:0]    fifoMem [FIFO_DEPTH];

  logic [PW-1:0] headQ, headD, tailQ, tailD;
  logic [CW-1:0] countQ, countD;
  logic          overflowQ, overflowD;
  logic [31:0]   cycleQ, cycleD;
  logic          faultQ, faultD;

  logic          rdRam, rdMmio, wrRam, wrMmio;
  logic          storeEn, misaligned, storeOk;
  logic          ramWe, conTxWe, statusWe, cycleWe;
  logic          fifoFull, fifoEmpty, pop, pushAccept;
  logic [3:0]    laneEn;
  logic [31:0]   laneData, ramWord, statusWord;

  // Address decode for both ports
  assign rdRam  = raddr < RAM_BYTES;
  assign rdMmio = raddr[31:6] == MMIO_BASE[31:6];
  assign wrRam  = waddr < RAM_BYTES;
  assign wrMmio = waddr[31:6] == MMIO_BASE[31:6];

  // Alignment applies to every mapped store, RAM or MMIO
  assign storeEn    = write_byte_en != 2'b00;
  assign misaligned = ((write_byte_en == 2'b10) && waddr[0]) ||
                      ((write_byte_en == 2'b11) && (waddr[1:0] != 2'b00));
  assign storeOk    = storeEn && !misaligned && (wrRam || wrMmio);
  assign faultD     = storeEn && (misaligned || !(wrRam || wrMmio));

  assign ramWe    = storeOk && wrRam;
  assign conTxWe  = storeOk && wrMmio && (waddr[5:2] == 4'h0);
  assign statusWe = storeOk && wrMmio && (waddr[5:2] == 4'h1);
  assign cycleWe  = storeOk && wrMmio && (waddr[5:2] == 4'h2);

  assign fifoFull   = countQ == CW'(FIFO_DEPTH);
  assign fifoEmpty  = countQ == '0;
  assign con_valid  = !fifoEmpty;
  assign con_data   = con_valid ? fifoMem[headQ] : 8'h00;
  assign pop        = con_valid && con_ready;
  // A push into a full FIFO still lands if the head leaves in the same cycle
  assign pushAccept = conTxWe && (!fifoFull || pop);

  assign statusWord = {24'h0, overflowQ, fifoFull, fifoEmpty, 5'(countQ)};
  assign ramWord    = mem[raddr[AW+1:2]];
  assign store_fault = faultQ;

  // Combinational load path: shift addressed byte to lane 0, zero-fill above
  always_comb begin
    rdata = 32'h0;
    if (rdRam) begin
      rdata = ramWord >> {raddr[1:0], 3'b000};
    end else if (rdMmio) begin
      case (raddr[5:2])
        4'h1:    rdata = statusWord;
        4'h2:    rdata = cycleQ;
        default: rdata = 32'h0;
      endcase
    end
  end

  // Replicate store data across lanes and pick the enabled lanes by size
  always_comb begin
    laneEn   = 4'b0000;
    laneData = 32'h0;
    case (write_byte_en)
      2'b01: begin
        laneEn   = 4'b0001 << waddr[1:0];
        laneData = {4{wdata[7:0]}};
      end
      2'b10: begin
        laneEn   = 4'b0011 << {waddr[1], 1'b0};
        laneData = {2{wdata[15:0]}};
      end
      2'b11: begin
        laneEn   = 4'b1111;
        laneData = wdata;
      end
      default: ;
    endcase
  end

  // RAM byte-lane writes; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int b = 0; b < 4; b++) begin
        if (laneEn[b]) mem[waddr[AW+1:2]][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

  // FIFO storage write; stale entries are masked by con_valid
  always_ff @(posedge clk) begin
    if (pushAccept) fifoMem[tailQ] <= wdata[7:0];
  end

  // FIFO pointers, occupancy, sticky overflow and cycle counter next state
  always_comb begin
    headD     = headQ;
    tailD     = tailQ;
    countD    = countQ;
    overflowD = overflowQ;
    if (pop)        headD = headQ + PW'(1);
    if (pushAccept) tailD = tailQ + PW'(1);
    if (pushAccept && !pop)      countD = countQ + CW'(1);
    else if (!pushAccept && pop) countD = countQ - CW'(1);
    if (conTxWe && fifoFull && !pop) overflowD = 1'b1;
    else if (statusWe)               overflowD = 1'b0;
    cycleD = cycleWe ? wdata : cycleQ + 32'd1;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headQ     <= '0;
      tailQ     <= '0;
      countQ    <= '0;
      overflowQ <= 1'b0;
      cycleQ    <= 32'h0;
      faultQ    <= 1'b0;
    end else begin
      headQ     <= headD;
      tailQ     <= tailD;
      countQ    <= countD;
      overflowQ <= overflowD;
      cycleQ    <= cycleD;
      faultQ    <= faultD;
    end
  end

endmodule

// File: tb/tb_sr_data_mem.sv
// Self-checking bench for sr_data_mem: vector table, hand-written FIFO,
// cycle-counter and reset sequences, then randomized traffic against a model.
module tb_sr_data_mem;

  localparam logic [31:0] CON_TX = 32'hFFFF_0000;
  localparam logic [31:0] STATUS = 32'hFFFF_0004;
  localparam logic [31:0] CYCLE  = 32'hFFFF_0008;
  localparam logic [31:0] NOWHERE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  write_byte_en;
  logic [31:0] raddr, rdata, waddr, wdata;
  logic [7:0]  con_data;
  logic        con_valid, con_ready, store_fault;

  int total = 0;
  int bad   = 0;

  // Reference model state for the randomized phase
  logic [7:0] refMem [64];
  logic [7:0] refQ [$];
  logic       refOvf;

  typedef struct {
    logic [1:0]  wbe;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] expRd;
    logic        expFault;
  } vec_t;

  vec_t vecs [18];

  sr_data_mem dut (
    .clk           (clk),
    .rst           (rst),
    .write_byte_en (write_byte_en),
    .raddr         (raddr),
    .rdata         (rdata),
    .waddr         (waddr),
    .wdata         (wdata),
    .con_data      (con_data),
    .con_valid     (con_valid),
    .con_ready     (con_ready),
    .store_fault   (store_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    write_byte_en = 2'b01;
    waddr         = CON_TX;
    wdata         = {24'h0, b};
    tick();
    write_byte_en = 2'b00;
  endtask

  task automatic readChk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(nm, rdata, exp);
  endtask

  // One random-phase cycle: drive, compare against the model, advance the model
  task automatic rcycle(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ra, input logic rdy);
    logic [31:0] expRd;
    logic        aligned, isRam, isMmio, expF, ok, full, doPop;
    write_byte_en = sz;
    waddr         = a;
    wdata         = wd;
    raddr         = ra;
    con_ready     = rdy;
    #1;
    expRd = 32'h0;
    if (ra < 64) begin
      for (int i = 0; i < 4; i++)
        if (int'(ra[1:0]) + i < 4) expRd[8*i +: 8] = refMem[int'(ra) + i];
    end else if (ra == STATUS) begin
      expRd = {24'h0, refOvf, refQ.size() == 8, refQ.size() == 0, 5'(refQ.size())};
    end
    chk("rand_rdata", rdata, expRd);
    chk("rand_valid", {31'h0, con_valid}, {31'h0, refQ.size() != 0});
    chk("rand_data", {24'h0, con_data}, {24'h0, (refQ.size() != 0) ? refQ[0] : 8'h00});

    aligned = !((sz == 2'b10) && a[0]) && !((sz == 2'b11) && (a[1:0] != 2'b00));
    isRam   = a < 32'd4096;
    isMmio  = (a & 32'hFFFF_FFC0) == 32'hFFFF_0000;
    expF    = (sz != 2'b00) && (!aligned || !(isRam || isMmio));
    ok      = (sz != 2'b00) && !expF;
    full    = refQ.size() == 8;
    doPop   = (refQ.size() != 0) && rdy;
    if (doPop) void'(refQ.pop_front());
    if (ok && isMmio && a[5:2] == 4'h0) begin
      if (!full || doPop) refQ.push_back(wd[7:0]);
      else refOvf = 1'b1;
    end
    if (ok && isMmio && a[5:2] == 4'h1) refOvf = 1'b0;
    if (ok && isRam && a < 64) begin
      refMem[int'(a)] = wd[7:0];
      if (sz != 2'b01) refMem[int'(a) + 1] = wd[15:8];
      if (sz == 2'b11) begin
        refMem[int'(a) + 2] = wd[23:16];
        refMem[int'(a) + 3] = wd[31:24];
      end
    end
    tick();
    chk("rand_fault", {31'h0, store_fault}, {31'h0, expF});
  endtask

  initial begin
    logic [31:0] c0;
    rst           = 1'b1;
    write_byte_en = 2'b00;
    raddr         = NOWHERE;
    waddr         = NOWHERE;
    wdata         = 32'h0;
    con_ready     = 1'b0;

    vecs[0]  = '{2'b11, 32'h10, 32'h1122_3344, NOWHERE, 32'h0, 1'b0};
    vecs[1]  = '{2'b00, 32'h0,  32'h0, 32'h11, 32'h0011_2233, 1'b0};
    vecs[2]  = '{2'b00, 32'h0,  32'h0, 32'h12, 32'h0000_1122, 1'b0};
    vecs[3]  = '{2'b00, 32'h0,  32'h0, 32'h13, 32'h0000_0011, 1'b0};
    vecs[4]  = '{2'b10, 32'h13, 32'h0000_BEEF, 32'h10, 32'h1122_3344, 1'b1};
    vecs[5]  = '{2'b00, 32'h0,  32'h0, 32'h10, 32'h1122_3344, 1'b0};
    vecs[6]  = '{2'b01, 32'h12, 32'h0000_55AA, 32'h12, 32'h0000_1122, 1'b0};
    vecs[7]  = '{2'b00, 32'h0,  32'h0, 32'h10, 32'h11AA_3344, 1'b0};
    vecs[8]  = '{2'b10, 32'h12, 32'h1234_BEEF, 32'h10, 32'h11AA_3344, 1'b0};
    vecs[9]  = '{2'b00, 32'h0,  32'h0, 32'h10, 32'hBEEF_3344, 1'b0};
    vecs[10] = '{2'b11, 32'h16, 32'hCAFE_F00D, 32'h10, 32'hBEEF_3344, 1'b1};
    vecs[11] = '{2'b11, 32'h1000, 32'hDEAD_0001, 32'h1000, 32'h0, 1'b1};
    vecs[12] = '{2'b11, 32'hFFC, 32'h0102_0304, 32'h1000, 32'h0, 1'b0};
    vecs[13] = '{2'b00, 32'h0,  32'h0, 32'hFFF, 32'h0000_0001, 1'b0};
    vecs[14] = '{2'b11, 32'hFFFF_003C, 32'h1234_5678, 32'hFFFF_003C, 32'h0, 1'b0};
    vecs[15] = '{2'b11, 32'hFFFF_0040, 32'h1, 32'hFFFF_0040, 32'h0, 1'b1};
    vecs[16] = '{2'b01, 32'h10, 32'h0000_0077, 32'h11, 32'h00BE_EF33, 1'b0};
    vecs[17] = '{2'b00, 32'h0,  32'h0, 32'h10, 32'hBEEF_3377, 1'b0};

    // Reset state
    #2;
    chk("rst_valid", {31'h0, con_valid}, 32'h0);
    chk("rst_data", {24'h0, con_data}, 32'h0);
    chk("rst_fault", {31'h0, store_fault}, 32'h0);
    readChk("rst_status", STATUS, 32'h0000_0020);
    readChk("rst_cycle", CYCLE, 32'h0);
    tick();
    rst = 1'b0;

    // Table-driven RAM and decode vectors
    for (int i = 0; i < 18; i++) begin
      write_byte_en = vecs[i].wbe;
      waddr         = vecs[i].waddr;
      wdata         = vecs[i].wdata;
      raddr         = vecs[i].raddr;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].expRd);
      tick();
      chk($sformatf("vec%0d_fault", i), {31'h0, store_fault}, {31'h0, vecs[i].expFault});
    end
    write_byte_en = 2'b00;
    readChk("contx_read", CON_TX, 32'h0);

    // Nine pushes into an 8-deep FIFO with the sink stalled
    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h41 + 8'(i));
    readChk("ovf_status", STATUS, 32'h0000_00C8);
    chk("ovf_head", {24'h0, con_data}, 32'h41);
    tick();
    tick();
    chk("stall_head", {24'h0, con_data}, 32'h41);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain%0d", i), {24'h0, con_data}, 32'h41 + i);
      tick();
    end
    con_ready = 1'b0;
    chk("drain_empty", {31'h0, con_valid}, 32'h0);
    readChk("drain_status", STATUS, 32'h0000_00A0);
    write_byte_en = 2'b11;
    waddr         = STATUS;
    wdata         = 32'h0;
    tick();
    write_byte_en = 2'b00;
    readChk("ovf_clear", STATUS, 32'h0000_0020);

    // Push into empty FIFO: no fall-through
    con_ready     = 1'b1;
    write_byte_en = 2'b01;
    waddr         = CON_TX;
    wdata         = 32'h78;
    #1;
    chk("nofall_valid", {31'h0, con_valid}, 32'h0);
    tick();
    write_byte_en = 2'b00;
    chk("rise_valid", {31'h0, con_valid}, 32'h1);
    chk("rise_data", {24'h0, con_data}, 32'h78);
    tick();
    chk("rise_drained", {31'h0, con_valid}, 32'h0);

    // Full FIFO with simultaneous push and pop
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    readChk("full_status", STATUS, 32'h0000_0048);
    con_ready     = 1'b1;
    write_byte_en = 2'b01;
    waddr         = CON_TX;
    wdata         = 32'h5A;
    tick();
    write_byte_en = 2'b00;
    con_ready     = 1'b0;
    readChk("pushpop_status", STATUS, 32'h0000_0048);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("pp_out%0d", i), {24'h0, con_data}, (i == 7) ? 32'h5A : 32'h31 + i);
      tick();
    end
    con_ready = 1'b0;
    chk("pp_empty", {31'h0, con_valid}, 32'h0);

    // Cycle counter: free running, wrap, write overrides increment
    raddr = CYCLE;
    #1;
    c0 = rdata;
    tick();
    tick();
    tick();
    chk("cycle_count", rdata, c0 + 32'd3);
    write_byte_en = 2'b11;
    waddr         = CYCLE;
    wdata         = 32'hFFFF_FFFF;
    tick();
    write_byte_en = 2'b00;
    chk("cycle_load", rdata, 32'hFFFF_FFFF);
    tick();
    chk("cycle_wrap", rdata, 32'h0);
    tick();
    chk("cycle_after", rdata, 32'h1);
    write_byte_en = 2'b01;
    wdata         = 32'h0000_0100;
    tick();
    write_byte_en = 2'b00;
    chk("cycle_byteload", rdata, 32'h0000_0100);
    tick();
    chk("cycle_byteinc", rdata, 32'h0000_0101);

    // Asynchronous reset with bytes queued
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("pre_rst_valid", {31'h0, con_valid}, 32'h1);
    raddr = STATUS;
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", {31'h0, con_valid}, 32'h0);
    chk("async_data", {24'h0, con_data}, 32'h0);
    chk("async_status", rdata, 32'h0000_0020);
    tick();
    rst = 1'b0;

    // Randomized traffic against the reference model
    refOvf = 1'b0;
    for (int w = 0; w < 16; w++) rcycle(2'b11, 32'(w * 4), $urandom(), NOWHERE, 1'b0);
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  sz;
      logic [31:0] a, ra;
      int          kind;
      sz   = 2'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 9));
      if (kind < 6)       a = 32'($urandom_range(0, 63));
      else if (kind < 8)  a = CON_TX;
      else if (kind == 8) a = STATUS;
      else                a = 32'h2000 + 32'($urandom_range(0, 255));
      ra = ($urandom_range(0, 4) == 0) ? STATUS : 32'($urandom_range(0, 63));
      rcycle(sz, a, $urandom(), ra, ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
